// File: rtl/conv_pkg.sv
// conv_pkg: constants and types shared by the layer-0 convolution slice.
//   - DW/AW/FRAC: data width (signed 4.16), address width, fraction bits
//   - K0..K8: 3x3 kernel in row-major order (K4 is the centre tap)
//   - BIAS: added after scaling, before ReLU
//   - CSEL_*: memory-select codes shared with the pooling stage
package conv_pkg;

    localparam int DW   = 20;
    localparam int AW   = 12;
    localparam int FRAC = 16;

    localparam logic [DW-1:0] K0 = 20'h0A89E;
    localparam logic [DW-1:0] K1 = 20'h092D5;
    localparam logic [DW-1:0] K2 = 20'h06D43;
    localparam logic [DW-1:0] K3 = 20'h01004;
    localparam logic [DW-1:0] K4 = 20'hF8F71;
    localparam logic [DW-1:0] K5 = 20'hF6E54;
    localparam logic [DW-1:0] K6 = 20'hFA6D7;
    localparam logic [DW-1:0] K7 = 20'hFC834;
    localparam logic [DW-1:0] K8 = 20'hFAC19;

    localparam logic [DW-1:0] BIAS = 20'h01310;

    localparam logic [2:0] CSEL_NONE = 3'b000;
    localparam logic [2:0] CSEL_L0   = 3'b001;
    localparam logic [2:0] CSEL_L1   = 3'b011;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_WRITE,
        S_FIN
    } state_e;

    // One layer-0 memory write.
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_req_t;

    function automatic logic [DW-1:0] kernel_coef(input logic [3:0] tap);
        case (tap)
            4'd0:    kernel_coef = K0;
            4'd1:    kernel_coef = K1;
            4'd2:    kernel_coef = K2;
            4'd3:    kernel_coef = K3;
            4'd4:    kernel_coef = K4;
            4'd5:    kernel_coef = K5;
            4'd6:    kernel_coef = K6;
            4'd7:    kernel_coef = K7;
            4'd8:    kernel_coef = K8;
            default: kernel_coef = '0;
        endcase
    endfunction

endpackage

// File: rtl/conv_l0_mac.sv
// conv_l0_mac: signed multiply-accumulate for one output pixel plus the
// scale / bias / ReLU post-processing of the accumulated sum.
//   clk, reset   clock, asynchronous active-low reset
//   en           a tap product is valid this cycle (idata belongs to tap)
//   clr          first tap of a pixel: acc restarts from this product
//   zero         padding tap: contributes 0 regardless of idata
//   tap          kernel index 0..8 selecting the coefficient
//   idata        image sample, signed 4.16
//   result       relu(scale(acc) + BIAS), valid once the last tap is in
// Optional: CONV_L0_ROUND_EN adds acc[15] before the bias (round-half-up);
// otherwise the scaled value is a plain truncation.
module conv_l0_mac
    import conv_pkg::*;
#(
    parameter int DW = 20
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          clr,
    input  logic          zero,
    input  logic [3:0]    tap,
    input  logic [DW-1:0] idata,
    output logic [DW-1:0] result
);

    localparam int ACC_W = 2 * DW;

    logic        [DW-1:0]    coef;
    logic signed [ACC_W-1:0] prod;
    logic signed [ACC_W-1:0] acc;
    logic        [DW-1:0]    scaled;
    logic        [DW-1:0]    biased;
    logic                    unused_acc_bits;

    assign coef = kernel_coef(tap);

    // Both operands sign-extended to the accumulator width so the product
    // is a full signed 40-bit result.
    always_comb begin
        prod = '0;
        if (!zero)
            prod = $signed({{DW{idata[DW-1]}}, idata}) * $signed({{DW{coef[DW-1]}}, coef});
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            acc <= '0;
        else if (en)
            acc <= (clr ? '0 : acc) + prod;
    end

    // 4.16 x 4.16 gives 8.32; bits [35:16] are the 4.16 result.
    always_comb begin
`ifdef CONV_L0_ROUND_EN
        scaled = acc[FRAC+DW-1:FRAC] + DW'(acc[FRAC-1]);
`else
        scaled = acc[FRAC+DW-1:FRAC];
`endif
        biased = scaled + BIAS;
        result = biased[DW-1] ? '0 : biased;
    end

    assign unused_acc_bits = ^{acc[ACC_W-1:FRAC+DW], acc[FRAC-1:0]};

endmodule

// File: rtl/conv_l0_engine.sv
// conv_l0_engine: layer-0 3x3 convolution over a 64x64 image with zero
// padding, bias and ReLU; results go to layer-0 memory for the max-pool.
//   clk, reset        clock, asynchronous active-low reset
//   start             one-cycle pulse, accepted only when idle
//   busy              high for the whole pass, drops with done
//   done              one-cycle pulse after the last write
//   iaddr / idata     image ROM port, data returns one cycle after address
//   cwr, caddr_wr,    layer-0 write strobe, {row,col} address, data
//   cdata_wr
//   csel              CSEL_L0 during a write, else 0
// Each pixel takes 11 cycles: 9 FETCH (one tap per cycle), 1 DRAIN for the
// last product to land in the accumulator, 1 WRITE.
// Build option CONV_L0_ROUND_EN (handled in conv_l0_mac) selects rounding.
module conv_l0_engine #(
    parameter int IMG_LOG2 = 6,
    parameter int DW       = 20,
    parameter int AW       = 2 * IMG_LOG2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] iaddr,
    input  logic [DW-1:0] idata,
    output logic          cwr,
    output logic [AW-1:0] caddr_wr,
    output logic [DW-1:0] cdata_wr,
    output logic [2:0]    csel
);
    import conv_pkg::*;

    // One extra bit lets row-1 / row+1 be seen as out of range (-1 or 64).
    localparam int IW = IMG_LOG2 + 1;

    state_e              state, nxt;
    logic [3:0]          tap_cnt;
    logic [IMG_LOG2-1:0] row, col;
    logic [1:0]          tr, tc;
    logic [IW-1:0]       r_ext, c_ext;
    logic                tap_oob;
    logic                last_pix;
    logic                fetch_d;
    logic [3:0]          tap_d;
    logic                oob_d;
    logic [DW-1:0]       mac_res;
    wr_req_t             wr;

    // Kernel position of the current tap, 0..2 in each direction.
    always_comb begin
        tr = 2'd0;
        tc = 2'd0;
        case (tap_cnt)
            4'd0: begin tr = 2'd0; tc = 2'd0; end
            4'd1: begin tr = 2'd0; tc = 2'd1; end
            4'd2: begin tr = 2'd0; tc = 2'd2; end
            4'd3: begin tr = 2'd1; tc = 2'd0; end
            4'd4: begin tr = 2'd1; tc = 2'd1; end
            4'd5: begin tr = 2'd1; tc = 2'd2; end
            4'd6: begin tr = 2'd2; tc = 2'd0; end
            4'd7: begin tr = 2'd2; tc = 2'd1; end
            4'd8: begin tr = 2'd2; tc = 2'd2; end
            default: begin tr = 2'd0; tc = 2'd0; end
        endcase
    end

    // Wraps to all-ones for -1 and sets the MSB for 64; either way the MSB
    // flags a padding tap, and the low bits still form a legal address.
    assign r_ext    = {1'b0, row} + IW'(tr) - IW'(1);
    assign c_ext    = {1'b0, col} + IW'(tc) - IW'(1);
    assign tap_oob  = r_ext[IW-1] | c_ext[IW-1];
    assign last_pix = (&row) & (&col);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            tap_cnt <= '0;
            row     <= '0;
            col     <= '0;
            fetch_d <= 1'b0;
            tap_d   <= '0;
            oob_d   <= 1'b0;
        end else begin
            state   <= nxt;
            // Tap bookkeeping delayed to line up with the ROM read latency.
            fetch_d <= (state == S_FETCH);
            tap_d   <= tap_cnt;
            oob_d   <= tap_oob;
            case (state)
                S_IDLE: begin
                    tap_cnt <= '0;
                    row     <= '0;
                    col     <= '0;
                end
                S_FETCH: tap_cnt <= (tap_cnt == 4'd8) ? '0 : tap_cnt + 4'd1;
                S_WRITE: begin
                    col <= col + IMG_LOG2'(1);
                    if (&col)
                        row <= row + IMG_LOG2'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:  if (start) nxt = S_FETCH;
            S_FETCH: if (tap_cnt == 4'd8) nxt = S_DRAIN;
            S_DRAIN: nxt = S_WRITE;
            S_WRITE: nxt = last_pix ? S_FIN : S_FETCH;
            S_FIN:   nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    conv_l0_mac #(.DW(DW)) u_mac (
        .clk    (clk),
        .reset  (reset),
        .en     (fetch_d),
        .clr    (tap_d == 4'd0),
        .zero   (oob_d),
        .tap    (tap_d),
        .idata  (idata),
        .result (mac_res)
    );

    // Outputs decode straight from state so a reset forces them to zero at
    // once, without waiting for a clock edge.
    always_comb begin
        wr       = '0;
        cwr      = (state == S_WRITE);
        if (cwr) begin
            wr.addr = {row, col};
            wr.data = mac_res;
        end
        caddr_wr = wr.addr;
        cdata_wr = wr.data;
        csel     = cwr ? CSEL_L0 : CSEL_NONE;
        busy     = (state == S_FETCH) || (state == S_DRAIN) || (state == S_WRITE);
        done     = (state == S_FIN);
        iaddr    = (state == S_FETCH) ? {r_ext[IMG_LOG2-1:0], c_ext[IMG_LOG2-1:0]} : '0;
    end

endmodule

// File: tb/tb_conv_l0_engine.sv
module tb_conv_l0_engine;

    localparam int NPIX = 4096;
    localparam logic [19:0] KERN [0:8] = '{20'h0A89E, 20'h092D5, 20'h06D43,
                                           20'h01004, 20'hF8F71, 20'hF6E54,
                                           20'hFA6D7, 20'hFC834, 20'hFAC19};
`ifdef CONV_L0_ROUND_EN
    localparam logic [19:0] EXP_RND = 20'h01311;
`else
    localparam logic [19:0] EXP_RND = 20'h01310;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, cwr;
    logic [11:0] iaddr, caddr_wr;
    logic [19:0] idata, cdata_wr;
    logic [2:0]  csel;

    logic [19:0] img     [NPIX];
    logic [19:0] ref_out [NPIX];
    logic [19:0] cap     [NPIX];

    int checks = 0, errors = 0;
    int cyc = 0, wr_cnt = 0, done_cnt = 0, done_cyc = 0, t_start = 0;

    conv_l0_engine dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .iaddr    (iaddr),
        .idata    (idata),
        .cwr      (cwr),
        .caddr_wr (caddr_wr),
        .cdata_wr (cdata_wr),
        .csel     (csel)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) idata <= img[iaddr];   // one-cycle ROM

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: zero-padded 3x3 correlation in wide integers, then scale,
    // optional round, bias with 20-bit wrap, ReLU on bit 19.
    function automatic logic [19:0] ref_pix(input int r, input int c);
        longint s = 0;
        longint v;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                if (r + dr >= 0 && r + dr < 64 && c + dc >= 0 && c + dc < 64)
                    s += longint'($signed(img[(r + dr) * 64 + c + dc]))
                       * longint'($signed(KERN[(dr + 1) * 3 + dc + 1]));
        v = (s >>> 16) & 64'hFFFFF;
`ifdef CONV_L0_ROUND_EN
        v = v + ((s >>> 15) & 64'd1);
`endif
        v = (v + 64'h01310) & 64'hFFFFF;
        return v[19] ? 20'h0 : v[19:0];
    endfunction

    task automatic build_ref();
        for (int p = 0; p < NPIX; p++) ref_out[p] = ref_pix(p / 64, p % 64);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_cwr"}, cwr, 0);
        chk({tag, "_caddr"}, caddr_wr, 0);
        chk({tag, "_cdata"}, cdata_wr, 0);
        chk({tag, "_csel"}, csel, 0);
        chk({tag, "_iaddr"}, iaddr, 0);
    endtask

    // Write scoreboard: strict ascending order, data against the model.
    always @(negedge clk) begin
        if (cwr) begin
            if (wr_cnt < NPIX) begin
                chk("wr_addr", caddr_wr, wr_cnt);
                chk("wr_data", cdata_wr, ref_out[wr_cnt]);
            end else begin
                chk("wr_extra", wr_cnt, NPIX - 1);
            end
            chk("wr_csel", csel, 3'b001);
            cap[caddr_wr] = cdata_wr;
            wr_cnt++;
        end
        if (done) begin
            chk("busy_at_done", busy, 0);
            done_cnt++;
            done_cyc = cyc;
        end
    end

    initial begin
        int n;
        for (int p = 0; p < NPIX; p++) img[p] = 20'h0;
        build_ref();

        // Reset state
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy, 0);

        // Frame 1: all-zero image, aborted by reset during pixel {20,7}
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        n = 0;
        while (wr_cnt < 20 * 64 + 7 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("wr_before_abort", wr_cnt, 20 * 64 + 7);
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_outputs("abort");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        chk("no_wr_after_abort", wr_cnt, 20 * 64 + 7);
        chk("idle_after_abort", busy, 0);
        chk("no_done_after_abort", done_cnt, 0);

        // Frame 2: composite image -- ones band at the top edge and in the
        // interior, impulse at {10,10}, LSB pixel at {5,5}, random bottom rows
        for (int r = 0; r < 64; r++)
            for (int c = 0; c < 64; c++) begin
                logic [19:0] v;
                v = 20'h0;
                if (r <= 2 || (r >= 30 && r <= 40)) v = 20'h10000;
                if (r >= 50) v = 20'($urandom);
                img[r * 64 + c] = v;
            end
        img[10 * 64 + 10] = 20'h10000;
        img[5 * 64 + 5]   = 20'h00001;
        build_ref();
        wr_cnt   = 0;
        done_cnt = 0;

        t_start = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (200) @(negedge clk);
        start = 1'b1;                       // must be ignored while busy
        @(negedge clk);
        start = 1'b0;

        n = 0;
        while (done_cnt == 0 && n < 50000) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", (done_cnt > 0), 1);
        repeat (30) @(negedge clk);
        chk("done_once", done_cnt, 1);
        chk("wr_count", wr_cnt, NPIX);
        chk("done_latency", done_cyc - t_start, NPIX * 11 + 1);
        chk("idle_after_frame", busy, 0);

        chk("imp_11_11", cap[11 * 64 + 11], 20'h0BBAE);
        chk("imp_10_11", cap[10 * 64 + 11], 20'h02314);
        chk("imp_10_10", cap[10 * 64 + 10], 20'h0);
        chk("imp_9_9",   cap[9 * 64 + 9],   20'h0);
        chk("round_6_6", cap[6 * 64 + 6],   EXP_RND);
        chk("corner_0_0", cap[0], 20'h0);
        chk("ones_interior", cap[35 * 64 + 30], 20'h0);
        chk("zero_region", cap[20 * 64 + 40], 20'h01310);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_l0_engine.md
Name: conv_l0_engine

Overview:
- Layer-0 convolution engine; sits directly upstream of the 2x2 max-pool stage.
- Reads the 64x64 grayscale image from the image ROM and applies a 3x3 kernel with zero padding.
- Adds the bias, applies ReLU, and writes 4096 results to the layer-0 memory (csel=3'b001), which the max-pool stage then consumes.
- The top-level FSM pulses start and waits for done before entering the pooling phase.

Parameters:
- IMG_LOG2, 6, log2 of image width/height (64).
- DW, 20, data width; signed fixed point 4.16.
- AW, 12, address width; equals 2*IMG_LOG2.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  single-cycle pulse; begins a full-frame pass when idle.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  single-cycle pulse after the last write.
- iaddr  out  AW  image ROM address, {row,col}.
- idata  in  DW  image data; valid one clock after iaddr is presented.
- cwr  out  1  layer-0 write strobe.
- caddr_wr  out  AW  write address, {row,col}.
- cdata_wr  out  DW  write data.
- csel  out  3  memory select; 3'b001 while cwr=1, else 3'b000.

Behaviour:
- Reset values: busy=0, done=0, cwr=0, caddr_wr=0, cdata_wr=0, csel=0, iaddr=0. FSM goes to IDLE and all counters clear.
- States: IDLE -> FETCH -> DRAIN -> WRITE -> (FETCH, or FIN when the last pixel is written) -> IDLE.
- IDLE: waits for start. start while busy is ignored.
- FETCH: 9 cycles. tap_cnt runs 0..8, kernel order row-major (k0=top-left ... k4=centre ... k8=bottom-right).
  - Each cycle issues iaddr = {row+dr, col+dc}, with dr,dc in {-1,0,+1}.
  - Out-of-bounds taps (row/col -1 or 64) are flagged. Their delayed flag forces the MAC operand to 0. iaddr for such a tap is don't-care but stays inside 0..4095.
- MAC: acc (40-bit signed) += idata * k[tap] one cycle after issue. Both operands are signed 20-bit. acc clears at tap 0.
- DRAIN: 1 cycle; absorbs the last product.
- WRITE: 1 cycle. cwr=1, csel=3'b001, caddr_wr={row,col}, cdata_wr=relu(round(acc)+BIAS).
  - Scaling: take acc[35:16], plus acc[15] when rounding is enabled (see Optional Feature).
  - Then add BIAS=20'h01310 (20-bit wrap). If bit19 is set, write 0.
- Per-pixel period is 11 cycles; full frame is 4096*11 cycles plus FIN.
- Scan order: col increments fastest. Wrap col 63->0 with row+1. After {63,63} is written, go to FIN.
- FIN: done=1 for one cycle, busy drops in the same cycle, then return to IDLE.
- Asserting reset mid-frame aborts immediately to the reset values above. No partial write occurs after reset deasserts.
- No back-pressure: layer-0 memory accepts a write every cycle.

Optional Feature:
- CONV_L0_ROUND_EN defined: round-half-up; adds acc[15] to acc[35:16] before the bias.
- Not defined: truncate (acc[35:16] only).

Decomposition:
- Shared package conv_pkg:
  - DW, AW, and FRAC=16.
  - Kernel constants K0..K8 = 20'h0A89E, 20'h092D5, 20'h06D43, 20'h01004, 20'hF8F71, 20'hF6E54, 20'hFA6D7, 20'hFC834, 20'hFAC19.
  - BIAS=20'h01310.
  - csel codes: CSEL_L0=3'b001, CSEL_L1=3'b011.
- Sub-module conv_l0_mac: multiplier, accumulator, and round/bias/ReLU post-processing, with clear, enable and zero-tap inputs. Address generation and the FSM stay in conv_l0_engine.

Test Plan:
- All-zero image, start pulse -> 4096 writes, each cdata_wr=20'h01310. done occurs exactly once, 4096*11+1 cycles after start; writes are in strict {row,col} ascending order.
- Impulse image (pixel {10,10}=20'h10000, others 0) -> out{11,11}=20'h0BBAE; out{10,11}=20'h02314; out{10,10}=0 (ReLU clamps negative k4 sum); out{9,9}=0.
- All pixels 20'h10000 -> interior outputs 0 (kernel sum -11869 plus bias is negative). Corner {0,0} = 0. Verify padding taps contribute 0 at all four edges against a reference model.
- Rounding: pixel {5,5}=20'h00001, others 0 -> out{6,6}=20'h01311 with CONV_L0_ROUND_EN, 20'h01310 without.
- Reset asserted (reset=0) mid-frame at pixel {20,7} -> all outputs return to their reset values within the same cycle and no further cwr occurs. A new start then gives a clean full frame matching the all-zero case.
- start pulsed while busy -> ignored; exactly 4096 writes and one done.
